// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, vector
// byte locations and the big-endian byte-lane helper.
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int VEC_BASE       = 252;
    localparam int VEC_OPCODE_IDX = 254;
    localparam int VEC_OVF_IDX    = 255;

    // Lane 0 is the most significant byte of the word (big-endian).
    function automatic logic [7:0] be_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        unique case (lane)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide RAM with four big-endian lanes starting at a base index; lane
// indices wrap modulo the array depth. Read is combinational.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [3:0]           wr_en,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data
);

    localparam int DEPTH = 2**ADDR_BITS;

    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx   [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i] = base + ADDR_BITS'(i);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) begin
                mem_q[idx[i]] <= be_lane(wr_data, 2'(i));
            end
        end
    end

    assign rd_data = {mem_q[idx[0]], mem_q[idx[1]], mem_q[idx[2]], mem_q[idx[3]]};

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: self-initialising byte RAM with protected exception
// vectors, registered big-endian word reads and per-access fault flags.
module mem_responder
    import mem_pkg::*;
#(
    parameter int         ADDR_BITS    = 8,
    parameter logic [7:0] VEC_OPCODE   = 8'd254,
    parameter logic [7:0] VEC_OVERFLOW = 8'd255,
    parameter bit         PROTECT_VEC  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ready,
    output logic        AddrFault,
    output logic        AlignFault,
    output logic        VecWriteFault
);

    localparam int DEPTH = 2**ADDR_BITS;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]          dout_q, dout_d;
    logic                 addr_fault_q, addr_fault_d;
    logic                 align_fault_q, align_fault_d;
    logic                 vec_fault_q, vec_fault_d;

    logic [ADDR_BITS-1:0] a;
    logic [ADDR_BITS-1:0] lane_idx [4];
    logic                 out_of_range;
    logic                 misaligned;
    logic [7:0]           init_byte;
    logic [3:0]           blocked;

    logic [ADDR_BITS-1:0] ram_base;
    logic [3:0]           ram_wen;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;

    assign a            = Address[ADDR_BITS-1:0];
    assign out_of_range = |Address[31:ADDR_BITS];
    assign misaligned   = |Address[1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_idx[i] = a + ADDR_BITS'(i);
            blocked[i]  = PROTECT_VEC && (int'(lane_idx[i]) >= VEC_BASE);
        end
    end

    always_comb begin
        init_byte = 8'd0;
        if (int'(cnt_q) == VEC_OPCODE_IDX) begin
            init_byte = VEC_OPCODE;
        end else if (int'(cnt_q) == VEC_OVF_IDX) begin
            init_byte = VEC_OVERFLOW;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        addr_fault_d  = 1'b0;
        align_fault_d = 1'b0;
        vec_fault_d   = 1'b0;
        ram_base      = a;
        ram_wen       = 4'b0000;
        ram_wdata     = Datain;

        unique case (state_q)
            INIT: begin
                // The sweep reuses lane 0 as a single-byte write port.
                ram_base  = cnt_q;
                ram_wen   = 4'b0001;
                ram_wdata = {init_byte, 24'd0};
                cnt_d     = cnt_q + 1'b1;
                dout_d    = '0;
                if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                addr_fault_d  = out_of_range;
                align_fault_d = misaligned;
                if (out_of_range) begin
                    dout_d = '0;
                end else if (Wr) begin
                    ram_wen     = ~blocked;
                    vec_fault_d = |blocked;
                    // Write-first: blocked lanes show the byte already stored.
                    for (int i = 0; i < 4; i++) begin
                        dout_d[31-8*i -: 8] = blocked[i] ? be_lane(ram_rdata, 2'(i))
                                                         : be_lane(Datain, 2'(i));
                    end
                end else begin
                    dout_d = ram_rdata;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            dout_q        <= '0;
            addr_fault_q  <= 1'b0;
            align_fault_q <= 1'b0;
            vec_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            addr_fault_q  <= addr_fault_d;
            align_fault_q <= align_fault_d;
            vec_fault_q   <= vec_fault_d;
        end
    end

    mem_byte_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clock  (clock),
        .base   (ram_base),
        .wr_en  (ram_wen),
        .wr_data(ram_wdata),
        .rd_data(ram_rdata)
    );

    assign Dataout       = dout_q;
    assign Ready         = (state_q == RUN);
    assign AddrFault     = addr_fault_q;
    assign AlignFault    = align_fault_q;
    assign VecWriteFault = vec_fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a byte-array reference model checked every cycle,
// plus directed accesses with hand-computed literal expectations.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'd0;
    logic        Wr = 1'b0;
    logic [31:0] Datain = 32'd0;
    logic [31:0] Dataout;
    logic        Ready;
    logic        AddrFault;
    logic        AlignFault;
    logic        VecWriteFault;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .ADDR_BITS   (8),
        .VEC_OPCODE  (8'd254),
        .VEC_OVERFLOW(8'd255),
        .PROTECT_VEC (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .Address      (Address),
        .Wr           (Wr),
        .Datain       (Datain),
        .Dataout      (Dataout),
        .Ready        (Ready),
        .AddrFault    (AddrFault),
        .AlignFault   (AlignFault),
        .VecWriteFault(VecWriteFault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a plain byte array, sweep as a count of
    // bytes initialised so far.
    logic [7:0]  m_mem [256];
    int          swept = 0;
    int          ma;
    int          mj;
    logic [31:0] m_dout = 32'd0;
    logic        m_ready = 1'b0;
    logic        m_af = 1'b0;
    logic        m_al = 1'b0;
    logic        m_vf = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            swept   = 0;
            m_ready = 1'b0;
            m_dout  = 32'd0;
            m_af    = 1'b0;
            m_al    = 1'b0;
            m_vf    = 1'b0;
        end else if (swept < 256) begin
            m_mem[swept] = (swept == 254) ? 8'hFE : (swept == 255) ? 8'hFF : 8'h00;
            swept++;
            m_ready = (swept == 256);
            m_dout  = 32'd0;
            m_af    = 1'b0;
            m_al    = 1'b0;
            m_vf    = 1'b0;
        end else begin
            ma   = int'(Address % 256);
            m_af = (Address > 32'd255);
            m_al = (Address % 4) != 0;
            m_vf = 1'b0;
            if (m_af) begin
                m_dout = 32'd0;
            end else begin
                if (Wr) begin
                    for (int i = 0; i < 4; i++) begin
                        mj = (ma + i) % 256;
                        if (mj >= 252) m_vf = 1'b1;
                        else m_mem[mj] = Datain[31-8*i -: 8];
                    end
                end
                m_dout = {m_mem[ma], m_mem[(ma+1)%256], m_mem[(ma+2)%256], m_mem[(ma+3)%256]};
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_ready",   {31'd0, Ready},         {31'd0, m_ready});
            check("model_dataout", Dataout,                m_dout);
            check("model_addrflt", {31'd0, AddrFault},     {31'd0, m_af});
            check("model_alignflt",{31'd0, AlignFault},    {31'd0, m_al});
            check("model_vecflt",  {31'd0, VecWriteFault}, {31'd0, m_vf});
        end
    end

    task automatic access(input logic [31:0] addr, input logic w, input logic [31:0] d);
        Address = addr;
        Wr      = w;
        Datain  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!Ready && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, n, 256);
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready",   {31'd0, Ready}, 32'd0);
        check("rst_dataout", Dataout,        32'd0);
        reset = 1'b0;
        Address = 32'd16;
        Wr      = 1'b1;
        Datain  = 32'hFFFF_FFFF;
        wait_ready("sweep_len");

        access(32'd252, 1'b0, 32'd0);
        check("vec_read", Dataout, 32'h0000FEFF);

        access(32'd16, 1'b1, 32'hDEADBEEF);
        check("wr16_dout", Dataout, 32'hDEADBEEF);
        access(32'd16, 1'b0, 32'd0);
        check("rd16", Dataout, 32'hDEADBEEF);
        access(32'd17, 1'b0, 32'd0);
        check("rd17", Dataout, 32'hADBEEF00);
        check("rd17_align", {31'd0, AlignFault}, 32'd1);

        access(32'd254, 1'b1, 32'h11223344);
        check("vecwr_fault", {31'd0, VecWriteFault}, 32'd1);
        check("vecwr_dout",  Dataout, 32'hFEFF3344);
        access(32'd0, 1'b0, 32'd0);
        check("wrap_bytes01", Dataout, 32'h33440000);
        check("wrap_vecflt",  {31'd0, VecWriteFault}, 32'd0);
        access(32'd252, 1'b0, 32'd0);
        check("vec_kept", Dataout, 32'h0000FEFF);

        access(32'h0000_0100, 1'b0, 32'd0);
        check("oor_rd_flt",  {31'd0, AddrFault}, 32'd1);
        check("oor_rd_dout", Dataout, 32'd0);
        access(32'h0000_0100, 1'b1, 32'hCAFEBABE);
        check("oor_wr_dout", Dataout, 32'd0);
        access(32'd0, 1'b0, 32'd0);
        check("oor_no_write", Dataout, 32'h33440000);
        access(32'h0000_0103, 1'b1, 32'h55555555);
        check("both_flt", {30'd0, AddrFault, AlignFault}, 32'd3);
        check("both_dout", Dataout, 32'd0);

        access(32'd0, 1'b1, 32'h00000102);
        access(32'd4, 1'b1, 32'h03040000);
        access(32'd2, 1'b0, 32'd0);
        check("mis_rd",   Dataout, 32'h01020304);
        check("mis_flag", {31'd0, AlignFault}, 32'd1);

        reset = 1'b1;
        Wr    = 1'b0;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        Address = 32'd16;
        Wr      = 1'b1;
        Datain  = 32'hFFFF_FFFF;
        repeat (100) @(posedge clock);
        #1;
        check("mid_ready", {31'd0, Ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_ready("resweep_len");
        access(32'd16, 1'b0, 32'd0);
        check("reinit16", Dataout, 32'd0);
        access(32'd252, 1'b0, 32'd0);
        check("reinit_vec", Dataout, 32'h0000FEFF);
        Wr = 1'b0;
        @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
